multi_cycle_ctrl: RTL and testbench

- Multi-cycle control FSM for the R/I-type MIPS datapath: register file, ALU, instruction register, PC, data memory.
- Sequences each instruction through FETCH, DECODE, EXEC, MEM and WB.
- Drives the datapath select and strobe signals: ALU_OP, rd_rt_s, rt_imm_s, imm_s, alu_mem_s, Write_Reg, Mem_Write.
- Stretches FETCH and MEM with a memory-ready handshake and a bounded timeout.

---
 rtl/multi_cycle_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller for the R/I-type MIPS datapath.
// Optional macro ILLEGAL_TRAP_EN: illegal encodings lock the controller in TRAP instead of retiring as NOP.
module multi_cycle_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_read,
  output logic       Mem_Write,
  output logic       Write_Reg,
  output logic [2:0] ALU_OP,
  output logic       rd_rt_s,
  output logic       rt_imm_s,
  output logic       imm_s,
  output logic       alu_mem_s,
  output logic       instr_done,
  output logic       bus_err,
  output logic [2:0] state,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    C_NOP,
    C_RTYPE,
    C_IARITH,
    C_LW,
    C_SW,
    C_ILL
  } cls_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  cls_t             cls_q, dec_cls;
  logic [2:0]       alu_q, dec_alu;
  logic             imm_q, dec_imm;
  logic             bus_err_q;
  logic             wait_st, timeout, fetch_ok, itype, sel_en;

  // Instruction decode; captured together with the IR so DECODE outputs stay Moore.
  always_comb begin
    dec_cls = C_ILL;
    dec_alu = 3'b000;
    dec_imm = 1'b0;
    case (op)
      6'b000000: begin
        dec_cls = C_RTYPE;
        case (funct)
          6'b100000: dec_alu = 3'b100;
          6'b100010: dec_alu = 3'b101;
          6'b100100: dec_alu = 3'b000;
          6'b100101: dec_alu = 3'b001;
          6'b100110: dec_alu = 3'b010;
          6'b100111: dec_alu = 3'b011;
          6'b101011: dec_alu = 3'b110;
          6'b000100: dec_alu = 3'b111;
          6'b000000: dec_cls = C_NOP;
          default:   dec_cls = C_ILL;
        endcase
      end
      6'b001000: begin dec_cls = C_IARITH; dec_alu = 3'b100; dec_imm = 1'b1; end
      6'b001100: begin dec_cls = C_IARITH; dec_alu = 3'b000; end
      6'b001110: begin dec_cls = C_IARITH; dec_alu = 3'b010; end
      6'b001011: begin dec_cls = C_IARITH; dec_alu = 3'b110; end
      6'b100011: begin dec_cls = C_LW;     dec_alu = 3'b100; dec_imm = 1'b1; end
      6'b101011: begin dec_cls = C_SW;     dec_alu = 3'b100; dec_imm = 1'b1; end
      default:   dec_cls = C_ILL;
    endcase
`ifndef ILLEGAL_TRAP_EN
    if (dec_cls == C_ILL) dec_cls = C_NOP;
`endif
  end

  assign wait_st  = (state_q == S_FETCH) || (state_q == S_MEM);
  assign timeout  = wait_st && !mem_ready && (cnt_q == CNT_LAST);
  assign fetch_ok = (state_q == S_FETCH) && mem_ready;
  // Leaving FETCH/MEM only happens on ready or timeout, so the count is zero on every entry.
  assign cnt_d    = (wait_st && !mem_ready && !timeout) ? cnt_q + CNT_W'(1) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      cls_q     <= C_NOP;
      alu_q     <= 3'b000;
      imm_q     <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (fetch_ok) begin
        cls_q <= dec_cls;
        alu_q <= dec_alu;
        imm_q <= dec_imm;
      end
      if (timeout) bus_err_q <= 1'b1;
    end
  end

  assign itype  = (cls_q == C_IARITH) || (cls_q == C_LW) || (cls_q == C_SW);
  assign sel_en = (state_q == S_DECODE) || (state_q == S_EXEC) ||
                  (state_q == S_MEM) || (state_q == S_WB);

  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    Mem_Write  = 1'b0;
    Write_Reg  = 1'b0;
    instr_done = 1'b0;
    ALU_OP     = sel_en ? alu_q : 3'b000;
    rd_rt_s    = sel_en && itype;
    rt_imm_s   = sel_en && itype;
    imm_s      = sel_en && imm_q;
    alu_mem_s  = sel_en && (cls_q == C_LW);
    case (state_q)
      S_IDLE: if (start) state_d = S_FETCH;
      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        case (cls_q)
          C_NOP: begin
            instr_done = 1'b1;
            state_d    = start ? S_FETCH : S_IDLE;
          end
          C_ILL:   state_d = S_TRAP;
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC: state_d = ((cls_q == C_LW) || (cls_q == C_SW)) ? S_MEM : S_WB;
      S_MEM: begin
        mem_read = (cls_q == C_LW);
        if (mem_ready) begin
          if (cls_q == C_SW) begin
            // The store retires in its ready cycle; a timed-out store never strobes.
            Mem_Write  = 1'b1;
            instr_done = 1'b1;
            state_d    = start ? S_FETCH : S_IDLE;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout) begin
          state_d = S_FETCH;
        end
      end
      S_WB: begin
        Write_Reg  = 1'b1;
        instr_done = 1'b1;
        state_d    = start ? S_FETCH : S_IDLE;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
  end

  assign state   = state_q;
  assign busy    = (state_q != S_IDLE);
  assign bus_err = bus_err_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: instruction-level model expands each instruction into its
// expected per-cycle phase sequence and compares every DUT output each cycle.
module tb_multi_cycle_ctrl;

  logic       clk, rst_n, start, mem_ready;
  logic [5:0] op, funct;
  logic       pc_write, ir_write, mem_read, Mem_Write, Write_Reg;
  logic [2:0] ALU_OP;
  logic       rd_rt_s, rt_imm_s, imm_s, alu_mem_s, instr_done, bus_err, busy;
  logic [2:0] state;

  multi_cycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .funct(funct), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read), .Mem_Write(Mem_Write),
    .Write_Reg(Write_Reg), .ALU_OP(ALU_OP), .rd_rt_s(rd_rt_s), .rt_imm_s(rt_imm_s),
    .imm_s(imm_s), .alu_mem_s(alu_mem_s), .instr_done(instr_done), .bus_err(bus_err),
    .state(state), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif
  localparam int TIMEOUT = 15;

  typedef enum int {P_IDLE = 0, P_FETCH = 1, P_DEC = 2, P_EXEC = 3, P_MEM = 4, P_WB = 5, P_TRAP = 6} ph_e;
  typedef enum int {C_NOP, C_R, C_I, C_LW, C_SW, C_ILL} cls_e;

  int         n_chk = 0, n_pass = 0, cyc = 0;
  logic [5:0] cur_op = '0, cur_funct = '0;
  cls_e       m_cls = C_NOP;
  logic [2:0] m_alu = '0;
  logic       m_ims = 1'b0;
  logic       bus_err_m = 1'b0;

  logic [17:0] dut_v;
  assign dut_v = {state, busy, pc_write, ir_write, mem_read, Mem_Write, Write_Reg, ALU_OP,
                  rd_rt_s, rt_imm_s, imm_s, alu_mem_s, instr_done, bus_err};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Instruction semantics straight from the opcode table.
  task automatic set_instr(input logic [5:0] o, input logic [5:0] f);
    cur_op = o; cur_funct = f;
    m_cls = C_ILL; m_alu = 3'b000; m_ims = 1'b0;
    if (o == 6'b000000) begin
      m_cls = C_R;
      case (f)
        6'b100000: m_alu = 3'b100;
        6'b100010: m_alu = 3'b101;
        6'b100100: m_alu = 3'b000;
        6'b100101: m_alu = 3'b001;
        6'b100110: m_alu = 3'b010;
        6'b100111: m_alu = 3'b011;
        6'b101011: m_alu = 3'b110;
        6'b000100: m_alu = 3'b111;
        6'b000000: m_cls = C_NOP;
        default:   m_cls = C_ILL;
      endcase
    end else if (o == 6'b001000) begin m_cls = C_I;  m_alu = 3'b100; m_ims = 1'b1; end
    else if (o == 6'b001100)     begin m_cls = C_I;  m_alu = 3'b000; end
    else if (o == 6'b001110)     begin m_cls = C_I;  m_alu = 3'b010; end
    else if (o == 6'b001011)     begin m_cls = C_I;  m_alu = 3'b110; end
    else if (o == 6'b100011)     begin m_cls = C_LW; m_alu = 3'b100; m_ims = 1'b1; end
    else if (o == 6'b101011)     begin m_cls = C_SW; m_alu = 3'b100; m_ims = 1'b1; end
  endtask

  function automatic logic [17:0] expv(input ph_e ph, input logic mr);
    logic sel, ity, idn;
    sel = (ph == P_DEC) || (ph == P_EXEC) || (ph == P_MEM) || (ph == P_WB);
    ity = (m_cls == C_I) || (m_cls == C_LW) || (m_cls == C_SW);
    idn = (ph == P_WB) ||
          (ph == P_DEC && (m_cls == C_NOP || (m_cls == C_ILL && !TRAP_EN))) ||
          (ph == P_MEM && m_cls == C_SW && mr);
    return {3'(ph), ph != P_IDLE, ph == P_FETCH && mr, ph == P_FETCH && mr,
            ph == P_FETCH || (ph == P_MEM && m_cls == C_LW),
            ph == P_MEM && m_cls == C_SW && mr, ph == P_WB,
            sel ? m_alu : 3'b000, sel && ity, sel && ity, sel && m_ims,
            sel && m_cls == C_LW, idn, bus_err_m};
  endfunction

  task automatic step(input ph_e ph, input logic mr, input logic st);
    @(negedge clk);
    mem_ready = mr; start = st; op = cur_op; funct = cur_funct;
    #1;
    cyc++;
    chk($sformatf("cycle%0d_phase%0d", cyc, int'(ph)), 32'(dut_v), 32'(expv(ph, mr)));
  endtask

  task automatic idle(input int n, input logic st_last);
    for (int i = 0; i < n - 1; i++) step(P_IDLE, 1'($urandom), 1'b0);
    step(P_IDLE, 1'($urandom), st_last);
  endtask

  // Expands one instruction: fw FETCH stalls, mw MEM stalls; start goes to st_end from EXEC on.
  task automatic instr(input logic [5:0] o, input logic [5:0] f, input int fw, input int mw,
                       input logic st_end);
    set_instr(o, f);
    for (int i = 0; i < fw; i++) step(P_FETCH, 1'b0, 1'b1);
    step(P_FETCH, 1'b1, 1'b1);
    if (m_cls == C_NOP || (m_cls == C_ILL && !TRAP_EN)) begin
      step(P_DEC, 1'($urandom), st_end);
      return;
    end
    if (m_cls == C_ILL) begin
      step(P_DEC, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) step(P_TRAP, 1'($urandom), 1'b1);
      return;
    end
    step(P_DEC, 1'($urandom), 1'b1);
    step(P_EXEC, 1'($urandom), st_end);
    if (m_cls == C_LW || m_cls == C_SW) begin
      for (int i = 0; i < mw && i < TIMEOUT; i++) step(P_MEM, 1'b0, st_end);
      if (mw >= TIMEOUT) begin
        bus_err_m = 1'b1;
        return;
      end
      step(P_MEM, 1'b1, st_end);
      if (m_cls == C_SW) return;
    end
    step(P_WB, 1'($urandom), st_end);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; mem_ready = 1'b0;
    #1;
    chk("async_reset_outputs_zero", 32'(dut_v), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus_err_m = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time bound expired, got running expected finished");
    $fatal(1);
  end

  logic [5:0] rfun [7];

  initial begin
    rfun = '{6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b100111, 6'b101011, 6'b000100};
    rst_n = 1'b0; start = 1'b0; mem_ready = 1'b0; op = '0; funct = '0;
    reset_dut();
    set_instr(6'b000000, 6'b000000);
    idle(2, 1'b1);

    // add, pinned by hand
    set_instr(6'b000000, 6'b100000);
    step(P_FETCH, 1'b1, 1'b1);
    chk("add_fetch_state", 32'(state), 32'd1);
    chk("add_fetch_ir_write", 32'(ir_write), 32'd1);
    step(P_DEC, 1'b1, 1'b1);
    chk("add_decode_state", 32'(state), 32'd2);
    step(P_EXEC, 1'b1, 1'b1);
    chk("add_exec_state", 32'(state), 32'd3);
    step(P_WB, 1'b1, 1'b1);
    chk("add_wb_state", 32'(state), 32'd5);
    chk("add_wb_alu_op", 32'(ALU_OP), 32'b100);
    chk("add_wb_write_reg", 32'(Write_Reg), 32'd1);
    chk("add_wb_rd_rt_s", 32'(rd_rt_s), 32'd0);
    chk("add_wb_instr_done", 32'(instr_done), 32'd1);

    foreach (rfun[i]) instr(6'b000000, rfun[i], 0, 0, 1'b1);
    instr(6'b000000, 6'b000000, 0, 0, 1'b1);
    instr(6'b001000, 6'b010101, 0, 0, 1'b1);
    instr(6'b001100, 6'b000000, 0, 0, 1'b1);
    instr(6'b001110, 6'b111111, 0, 0, 1'b1);
    instr(6'b001011, 6'b000000, 0, 0, 1'b1);
    instr(6'b100011, 6'b000000, 2, 3, 1'b1);

    // sw, pinned by hand
    set_instr(6'b101011, 6'b000000);
    step(P_FETCH, 1'b1, 1'b1);
    step(P_DEC, 1'b1, 1'b1);
    step(P_EXEC, 1'b1, 1'b1);
    step(P_MEM, 1'b1, 1'b1);
    chk("sw_mem_write", 32'(Mem_Write), 32'd1);
    chk("sw_instr_done", 32'(instr_done), 32'd1);
    chk("sw_no_write_reg", 32'(Write_Reg), 32'd0);

    instr(6'b101011, 6'b000000, 0, 2, 1'b1);
    instr(6'b000000, 6'b100000, TIMEOUT - 1, 0, 1'b1);
    chk("fetch_14_waits_no_bus_err", 32'(bus_err), 32'd0);

    // andi with start dropped in EXEC: WB still completes, then IDLE
    instr(6'b001100, 6'b000000, 0, 0, 1'b0);
    idle(2, 1'b1);

    // FETCH timeout
    set_instr(6'b000000, 6'b100000);
    for (int i = 0; i < TIMEOUT; i++) step(P_FETCH, 1'b0, 1'b1);
    bus_err_m = 1'b1;
    step(P_FETCH, 1'b1, 1'b1);
    chk("fetch_timeout_bus_err", 32'(bus_err), 32'd1);
    chk("fetch_timeout_state", 32'(state), 32'd1);
    step(P_DEC, 1'b1, 1'b1);
    step(P_EXEC, 1'b1, 1'b1);
    step(P_WB, 1'b1, 1'b1);

    // reset while lw sits in MEM
    set_instr(6'b100011, 6'b000000);
    step(P_FETCH, 1'b1, 1'b1);
    step(P_DEC, 1'b1, 1'b1);
    step(P_EXEC, 1'b1, 1'b1);
    reset_dut();
    step(P_IDLE, 1'b1, 1'b0);
    chk("reset_clears_bus_err", 32'(bus_err), 32'd0);
    idle(1, 1'b1);

    // sw MEM timeout: no store, back to FETCH
    instr(6'b101011, 6'b000000, 0, TIMEOUT, 1'b1);
    instr(6'b000000, 6'b100101, 0, 0, 1'b0);
    chk("mem_timeout_bus_err", 32'(bus_err), 32'd1);
    idle(1, 1'b1);

    // illegal encodings
    instr(6'b000000, 6'b000001, 0, 0, 1'b1);
    reset_dut();
    idle(1, 1'b1);
    instr(6'b111111, 6'b000000, 0, 0, 1'b1);
    reset_dut();
    step(P_IDLE, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
